// File: rtl/maxnet_pkg.sv
// Shared constants, the iteration-counter width helper and the status
// record committed at the end of each MaxNet iteration.
package maxnet_pkg;

   localparam int NEURONS   = 4;
   localparam int WIDTH     = 8;
   localparam int EPS_SHIFT = 2;
   localparam int MAX_ITER  = 16;

   // Counter must be able to hold MAX_ITER itself (saturation value).
   function automatic int iter_width(input int max_iter);
      return $clog2(max_iter) + 1;
   endfunction

   typedef struct packed {
      logic [1:0]       idx;   // lowest index with a non-zero activation
      logic [WIDTH-1:0] val;   // activation at idx, 0 if none
      logic [2:0]       nz;    // number of non-zero activations
      logic             to;    // more than one survivor at commit
   } status_t;

endpackage

// File: rtl/maxnet_neuron_update.sv
// One neuron's lateral-inhibition step: subtract eps * (sum of the other
// activations) from this activation, clamping at zero.
module maxnet_neuron_update #(
   parameter int WIDTH     = 8,
   parameter int EPS_SHIFT = 2
) (
   input  logic [WIDTH-1:0] a_self,
   input  logic [WIDTH-1:0] a_other0,
   input  logic [WIDTH-1:0] a_other1,
   input  logic [WIDTH-1:0] a_other2,
   output logic [WIDTH-1:0] next_val
);

   logic [WIDTH+1:0] sum_s;
   logic [WIDTH+1:0] dec_s;

   // Sum is two bits wider than an activation so three operands never wrap.
   always_comb begin
      sum_s = {2'b00, a_other0} + {2'b00, a_other1} + {2'b00, a_other2};
      dec_s = sum_s >> EPS_SHIFT;
      if (dec_s >= {2'b00, a_self}) begin
         next_val = '0;
      end else begin
         next_val = a_self - dec_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/maxnet_datapath.sv
// MaxNet responder datapath: input latch, activation and next-value
// registers, iteration counter, status and host-visible result registers.
// Sequencing is owned by the external controller through the strobes.
module maxnet_datapath
   import maxnet_pkg::*;
#(
   parameter int WIDTH     = maxnet_pkg::WIDTH,
   parameter int EPS_SHIFT = maxnet_pkg::EPS_SHIFT,
   parameter int MAX_ITER  = maxnet_pkg::MAX_ITER
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sel,
   input  logic                              en0,
   input  logic                              en1,
   input  logic                              en2,
   input  logic                              en3,
   input  logic                              done,
   input  logic [WIDTH-1:0]                  din0,
   input  logic [WIDTH-1:0]                  din1,
   input  logic [WIDTH-1:0]                  din2,
   input  logic [WIDTH-1:0]                  din3,
   output logic                              complete,
   output logic [1:0]                        winner_idx,
   output logic [WIDTH-1:0]                  winner_val,
   output logic                              no_winner,
   output logic                              timeout,
   output logic [iter_width(MAX_ITER)-1:0]   iter_count,
   output logic                              result_valid
);

   localparam int ITER_W = iter_width(MAX_ITER);

   logic [WIDTH-1:0] latch_r [NEURONS];
   logic [WIDTH-1:0] a_r     [NEURONS];
   logic [WIDTH-1:0] p_r     [NEURONS];
   logic [WIDTH-1:0] next_s  [NEURONS];
   status_t          status_r;
   status_t          status_s;
   logic             found_s;

   // Each neuron sees itself and the other three activations in rotation.
   for (genvar i = 0; i < NEURONS; i++) begin : g_neuron
      maxnet_neuron_update #(
         .WIDTH     (WIDTH),
         .EPS_SHIFT (EPS_SHIFT)
      ) u_update (
         .a_self   (a_r[i]),
         .a_other0 (a_r[(i + 1) % NEURONS]),
         .a_other1 (a_r[(i + 2) % NEURONS]),
         .a_other2 (a_r[(i + 3) % NEURONS]),
         .next_val (next_s[i])
      );
   end

   // Survivor count, lowest surviving index and its value, taken from p.
   always_comb begin
      status_s = '0;
      found_s  = 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
         status_s.nz = status_s.nz + {2'b00, |p_r[i]};
         if (!found_s && (|p_r[i])) begin
            status_s.idx = 2'(i);
            status_s.val = p_r[i];
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      status_s.to = (status_s.nz > 3'd1);
   end

   // Sequencer samples this after en2 and during en3; p and the count are stable then.
   always_comb begin
      complete = (status_s.nz <= 3'd1) || (iter_count == ITER_W'(MAX_ITER - 1));
   end

   // Input latch captures the initial activations on en0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NEURONS; i++) latch_r[i] <= '0;
      end else if (en0) begin
         latch_r[0] <= din0;
         latch_r[1] <= din1;
         latch_r[2] <= din2;
         latch_r[3] <= din3;
      end
   end

   // Neuron registers load from the input latch (start) or from p (next iteration).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NEURONS; i++) a_r[i] <= '0;
      end else if (en1) begin
         for (int i = 0; i < NEURONS; i++) a_r[i] <= sel ? latch_r[i] : p_r[i];
      end
   end

   // Next-value register captures the inhibition result computed from current a.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NEURONS; i++) p_r[i] <= '0;
      end else if (en2) begin
         for (int i = 0; i < NEURONS; i++) p_r[i] <= next_s[i];
      end
   end

   // Iteration counter: cleared by a new start, saturates at the cap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_count <= '0;
      end else if (en0) begin
         iter_count <= '0;
      end else if (en3 && (iter_count != ITER_W'(MAX_ITER))) begin
         iter_count <= iter_count + ITER_W'(1);
      end
   end

   // Status snapshot of p at each committed iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_r <= '0;
      end else if (en3) begin
         status_r <= status_s;
      end
   end

   // Host result registers; winner fields are forced to 0 when there is no winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         winner_idx <= 2'd0;
         winner_val <= '0;
         no_winner  <= 1'b0;
         timeout    <= 1'b0;
      end else if (done) begin
         if ((status_r.nz == 3'd0) || status_r.to) begin
            winner_idx <= 2'd0;
            winner_val <= '0;
            no_winner  <= 1'b1;
         end else begin
            winner_idx <= status_r.idx;
            winner_val <= status_r.val;
            no_winner  <= 1'b0;
         end
         timeout <= status_r.to;
      end
   end

   // Result-valid flag: set by done, dropped when a new run starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_valid <= 1'b0;
      end else if (en0) begin
         result_valid <= 1'b0;
      end else if (done) begin
         result_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_maxnet_datapath.sv
// Directed self-checking bench for maxnet_datapath.
module tb_maxnet_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel, en0, en1, en2, en3, done;
   logic [7:0] din0, din1, din2, din3;
   logic       complete;
   logic [1:0] winner_idx;
   logic [7:0] winner_val;
   logic       no_winner;
   logic       timeout;
   logic [4:0] iter_count;
   logic       result_valid;

   int checks_total  = 0;
   int checks_passed = 0;

   maxnet_datapath dut (
      .clk          (clk),
      .rst          (rst),
      .sel          (sel),
      .en0          (en0),
      .en1          (en1),
      .en2          (en2),
      .en3          (en3),
      .done         (done),
      .din0         (din0),
      .din1         (din1),
      .din2         (din2),
      .din3         (din3),
      .complete     (complete),
      .winner_idx   (winner_idx),
      .winner_val   (winner_val),
      .no_winner    (no_winner),
      .timeout      (timeout),
      .iter_count   (iter_count),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_strobes();
      sel = 1'b0; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; done = 1'b0;
   endtask

   task automatic start(input logic [7:0] d0, d1, d2, d3);
      din0 = d0; din1 = d1; din2 = d2; din3 = d3;
      idle_strobes(); en0 = 1'b1;
      step();
      idle_strobes(); en1 = 1'b1; sel = 1'b1;
      step();
      idle_strobes();
   endtask

   // One iteration: en2, idle, en1+en3 with complete checked in the en3 cycle.
   task automatic iterate(input logic exp_complete, input string tag);
      idle_strobes(); en2 = 1'b1;
      step();
      idle_strobes();
      step();
      en1 = 1'b1; en3 = 1'b1;
      check(tag, 32'(complete), 32'(exp_complete));
      step();
      idle_strobes();
   endtask

   task automatic finish_run();
      idle_strobes(); done = 1'b1;
      step();
      idle_strobes();
   endtask

   task automatic check_results(input string tag, input logic [1:0] idx, input logic [7:0] val,
                                input logic nw, input logic to, input logic [4:0] it);
      check({tag, "_idx"},   32'(winner_idx),   32'(idx));
      check({tag, "_val"},   32'(winner_val),   32'(val));
      check({tag, "_nw"},    32'(no_winner),    32'(nw));
      check({tag, "_to"},    32'(timeout),      32'(to));
      check({tag, "_iter"},  32'(iter_count),   32'(it));
      check({tag, "_valid"}, 32'(result_valid), 32'd1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_idx"},   32'(winner_idx),   32'd0);
      check({tag, "_val"},   32'(winner_val),   32'd0);
      check({tag, "_nw"},    32'(no_winner),    32'd0);
      check({tag, "_to"},    32'(timeout),      32'd0);
      check({tag, "_iter"},  32'(iter_count),   32'd0);
      check({tag, "_valid"}, 32'(result_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle_strobes();
      din0 = 8'd0; din1 = 8'd0; din2 = 8'd0; din3 = 8'd0;
      step();
      step();
      check_cleared("reset");
      rst = 1'b0;
      step();

      // 100,20,10,5: one iteration leaves (92,0,0,0).
      start(8'd100, 8'd20, 8'd10, 8'd5);
      iterate(1'b1, "single_it1_complete");
      finish_run();
      check_results("single", 2'd0, 8'd92, 1'b0, 1'b0, 5'd1);

      // Reset in the middle of an 80,40 run clears everything, including old results.
      start(8'd80, 8'd40, 8'd0, 8'd0);
      iterate(1'b0, "midrst_it1_complete");
      iterate(1'b0, "midrst_it2_complete");
      rst = 1'b1;
      step();
      check_cleared("midrst");
      rst = 1'b0;
      step();

      // Fresh 80,40 run: (70,20) -> (65,3) -> (65,0).
      start(8'd80, 8'd40, 8'd0, 8'd0);
      iterate(1'b0, "two_it1_complete");
      iterate(1'b0, "two_it2_complete");
      iterate(1'b1, "two_it3_complete");
      finish_run();
      check_results("two", 2'd0, 8'd65, 1'b0, 1'b0, 5'd3);

      // All zero inputs: no survivors.
      start(8'd0, 8'd0, 8'd0, 8'd0);
      iterate(1'b1, "zero_it1_complete");
      finish_run();
      check_results("zero", 2'd0, 8'd0, 1'b1, 1'b0, 5'd1);

      // Tie 50,50 stalls at (3,3); complete only forced by the cap.
      start(8'd50, 8'd50, 8'd0, 8'd0);
      for (int k = 1; k <= 15; k++) iterate(1'b0, $sformatf("tie_it%0d_complete", k));
      iterate(1'b1, "tie_it16_complete");
      finish_run();
      check_results("tie", 2'd0, 8'd0, 1'b1, 1'b1, 5'd16);

      // Same-cycle en1(sel)+en2: p from old a (80,40), a from new latch (100,20,10,5).
      start(8'd80, 8'd40, 8'd0, 8'd0);
      din0 = 8'd100; din1 = 8'd20; din2 = 8'd10; din3 = 8'd5;
      en0 = 1'b1;
      step();
      idle_strobes(); en1 = 1'b1; sel = 1'b1; en2 = 1'b1;
      step();
      idle_strobes();
      check("same_p_old_a_complete", 32'(complete), 32'd0);
      en2 = 1'b1;
      step();
      idle_strobes();
      check("same_a_new_complete", 32'(complete), 32'd1);
      en3 = 1'b1;
      step();
      finish_run();
      check_results("same", 2'd0, 8'd92, 1'b0, 1'b0, 5'd1);

      // A new en0 after done drops result_valid and the iteration count.
      en0 = 1'b1;
      step();
      idle_strobes();
      check("restart_valid", 32'(result_valid), 32'd0);
      check("restart_iter",  32'(iter_count),   32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/maxnet_datapath.md
Name: maxnet_datapath

Overview:
- Responder side of the four-neuron MaxNet start/complete handshake.
- Consumes the sequencer strobes (sel, en0..en3, done), runs one lateral-inhibition iteration per strobe cycle, and returns complete when at most one neuron remains non-zero or the iteration cap is hit.
- Latches the winner index, winner value and status flags for the host when done is asserted.

Parameters:
- WIDTH, 8, unsigned activation width per neuron.
- EPS_SHIFT, 2, inhibition weight eps = 2^-EPS_SHIFT (right shift of the sum of the other neurons).
- MAX_ITER, 16, iteration cap; forces complete on the MAX_ITER-th iteration.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  neuron-register source: 1 = input latch, 0 = next-value register.
- en0  input  1  load input latch from din0..din3.
- en1  input  1  load neuron registers from the source selected by sel.
- en2  input  1  capture computed next values into the next-value register.
- en3  input  1  commit-iteration strobe: iter_count+1, update status.
- done  input  1  latch result outputs.
- din0..din3  input  WIDTH each  unsigned initial activations.
- complete  output  1  combinational; iteration finished (see Behaviour).
- winner_idx  output  2  index of the surviving neuron.
- winner_val  output  WIDTH  surviving activation.
- no_winner  output  1  zero survivors, or timeout.
- timeout  output  1  cap reached with more than one survivor.
- iter_count  output  5 (clog2(MAX_ITER)+1)  committed iterations.
- result_valid  output  1  result outputs valid.

Behaviour:
- Reset: all registers and outputs are 0, including the input latch, a[0..3], p[0..3], iter_count, the result registers and result_valid.
- Per neuron i:
  - s_i = sum of a[j] for j != i, width WIDTH+2.
  - d_i = s_i >> EPS_SHIFT.
  - next_i = (d_i >= a[i]) ? 0 : a[i] - d_i.
  - All combinational, no wrap, clamped at 0.
- en0: input latch <= din0..din3. en0 also clears iter_count and result_valid.
- en1 & sel: a <= input latch. en1 & !sel: a <= p.
- en2: p <= next.
- complete = (popcount(p != 0) <= 1) || (iter_count == MAX_ITER-1).
  - complete is purely combinational from p and iter_count.
  - It is stable in the cycle after en2 and in the en3 cycle, where the sequencer samples it.
- en3: iter_count <= iter_count+1, saturating at MAX_ITER. The internal status registers update from p:
  - win_idx = lowest index with p != 0.
  - win_val = p[win_idx], or 0 if none.
  - nz = popcount.
  - to = (nz > 1).
- done: winner_idx/winner_val <= status; no_winner <= (nz == 0) || to; timeout <= to; result_valid <= 1.
  - Results hold until the next en0 or rst.
  - winner_idx and winner_val read 0 when no_winner is set.
- Simultaneous strobes: each register has exactly one enable, so any combination is legal and acts independently. en1 & en2 in the same cycle uses pre-edge a.
- Ties: equal maxima decay symmetrically. They reach 0 together (no_winner, timeout=0) or stall (timeout=1 at the cap).
- Reset asserted mid-iteration: immediate clear; the next start sequence behaves as from power-up.
- Single-cycle strobe latency everywhere. No internal FSM; sequencing is owned by the controller. Iteration cost is 3 cycles (en2, idle, en1+en3).

Decomposition:
- Shared package: NEURONS=4, WIDTH, EPS_SHIFT, MAX_ITER, the iter_count width function, and the status struct {idx, val, nz, to}.
- Sub-module maxnet_neuron_update is instanced 4x. It takes a[i] and the other three activations and produces next_i (sum, shift, clamp).

Test Plan:
- rst mid-run after iteration 2 of the inputs 80,40,0,0 -> all outputs 0 next cycle. A fresh run with the same inputs gives identical results.
- WIDTH=8, EPS_SHIFT=2, inputs 100,20,10,5 -> next = 92,0,0,0; complete=1 at first en3. After done: winner_idx=0, winner_val=92, iter_count=1, no_winner=0, timeout=0.
- Inputs 80,40,0,0 -> a = (70,20), then (65,3), then (65,0). complete=0 at iterations 1-2 and 1 at iteration 3. After done: winner_idx=0, winner_val=65, iter_count=3.
- Inputs 0,0,0,0 -> complete=1 at first en3. After done: no_winner=1, timeout=0, iter_count=1.
- Inputs 50,50,0,0 -> stall at (3,3) from iteration 11. complete=1 only at iteration 16. After done: timeout=1, no_winner=1, iter_count=16.
- Same-cycle en1/en2 check: a and p load independently, with p computed from pre-edge a. A second en0 after done clears result_valid and iter_count.
